uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_core.sv | 125 ++++++++++++
 tb/tb_uart_tx_core.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit constants: FSM encoding, frame geometry, parity enable.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // start + data + optional parity + stop
  localparam int FRAME_BITS = 2 + DATA_BITS + (PARITY_EN ? 1 : 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef logic [DATA_BITS-1:0] uart_byte_t;

  function automatic logic even_parity(input uart_byte_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; wrap-bit pointers give full/empty,
// occupancy is kept in its own register so readiness never sees a comb path.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  uart_byte_t               push_data,
  input  logic                     pop,
  output uart_byte_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  uart_byte_t  mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a push while full is dropped even if a pop frees a slot this same edge
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-fed 8N1 framer, optional even parity bit when
// UART_TX_PARITY_EN is defined (port list is the same either way).
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO entry
// START  | driving start bit (0)
// DATA   | shifting 8 data bits, LSB first
// PARITY | even parity of the byte (parity builds only)
// STOP   | driving stop bit (1); chains straight into START if FIFO has data
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 10417,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          UART_TX,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  uart_byte_t  shift_q;
  logic        tx_q;
  logic        baud_done;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  uart_byte_t  fifo_head;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign baud_done = (baud_cnt == 16'(BAUD_DIV - 1));
  assign fifo_pop  = ((state == ST_IDLE) || (state == ST_STOP && baud_done)) && !fifo_empty;
  assign tx_ready  = (fifo_count < CW'(FIFO_DEPTH));
  assign tx_busy   = (state != ST_IDLE) || !fifo_empty;
  assign UART_TX   = tx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (fifo_pop) begin
      // load the byte and put the start bit on the line in the same edge
      state    <= ST_START;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= fifo_head;
      tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= even_parity(fifo_head);
`endif
    end else if (state == ST_IDLE) begin
      tx_q <= 1'b1;
    end else if (!baud_done) begin
      baud_cnt <= baud_cnt + 16'd1;
    end else begin
      baud_cnt <= '0;
      case (state)
        ST_START: begin
          state <= ST_DATA;
          tx_q  <= shift_q[0];
        end
        ST_DATA: begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            state <= ST_PARITY;
            tx_q  <= parity_q;
`else
            state <= ST_STOP;
            tx_q  <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state <= ST_STOP;
          tx_q  <= 1'b1;
        end
`endif
        ST_STOP: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core (BAUD_DIV=4, FIFO_DEPTH=4): timeline
// model of the serial line plus literal checks; honours UART_TX_PARITY_EN.
module tb_uart_tx_core;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       UART_TX;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_tx_core #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .UART_TX    (UART_TX),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, current frame as a bit vector on a cycle timeline
  logic [7:0]    mq[$];
  bit            m_act = 1'b0;
  int            m_t = 0;
  logic [NB-1:0] m_frame = '1;
  bit            m_acc;
  logic [7:0]    m_byte;

  function automatic logic [NB-1:0] build_frame(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_act = 1'b0;
      m_t   = 0;
    end else begin
      m_acc = tx_valid && (mq.size() < DEPTH);
      if (m_act) begin
        m_t++;
        if (m_t == FRAME_CYC) m_act = 1'b0;
      end
      if (!m_act && mq.size() > 0) begin
        m_byte  = mq.pop_front();
        m_frame = build_frame(m_byte);
        m_act   = 1'b1;
        m_t     = 0;
      end
      if (m_acc) mq.push_back(tx_data);
    end
  end

  function automatic logic m_line();
    return m_act ? m_frame[m_t / BAUD] : 1'b1;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      check("line",  UART_TX,    m_line());
      check("ready", tx_ready,   mq.size() < DEPTH);
      check("busy",  tx_busy,    m_act || mq.size() > 0);
      check("count", fifo_count, mq.size());
    end
  end

  logic line_s [0:127];
  logic busy_s [0:127];

  task automatic sample_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      line_s[i] = UART_TX;
      busy_s[i] = tx_busy;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tx_busy || m_act) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", n < 5000, 1);
  endtask

  // Present a byte and hold it until accepted; returns the edge index of acceptance.
  task automatic send(input logic [7:0] d, output int waited);
    waited = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_timeout", waited < 500, 1);
    @(posedge clk); #1;
    waited++;
  endtask

  logic [NB-1:0] exp55;
  int w;
  int acc_edge [6];
  int edge_no;
  int low_cnt;

  initial begin
`ifdef UART_TX_PARITY_EN
    exp55 = 11'b10010101010;
`else
    exp55 = 10'b1010101010;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_line",  UART_TX,    1);
    check("rst_ready", tx_ready,   1);
    check("rst_busy",  tx_busy,    0);
    check("rst_count", fifo_count, 0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 0x55 from idle: start bit on the edge after the push, frame of FRAME_CYC cycles
    tx_data = 8'h55; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    sample_n(FRAME_CYC + 1);
    for (int b = 0; b < NB; b++) begin
      check("f55_bit_first", line_s[b*BAUD],          exp55[b]);
      check("f55_bit_last",  line_s[b*BAUD + BAUD-1], exp55[b]);
    end
    check("f55_busy_in",   busy_s[FRAME_CYC-1], 1);
    check("f55_busy_done", busy_s[FRAME_CYC],   0);
    check("f55_idle_line", line_s[FRAME_CYC],   1);

    // back-to-back 0xA5, 0x3C: no gap between stop and next start
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h3C;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    line_s[0] = UART_TX;
    busy_s[0] = tx_busy;
    check("b2b_start_a5", line_s[0], 0);
    sample_n(2*FRAME_CYC);
    check("b2b_a5_stop",   line_s[FRAME_CYC-2],   1);
    check("b2b_3c_start",  line_s[FRAME_CYC-1],   0);
    check("b2b_3c_bit2",   line_s[FRAME_CYC-1 + 3*BAUD], 1);
    check("b2b_3c_bit0",   line_s[FRAME_CYC-1 + 1*BAUD], 0);
    check("b2b_busy_mid",  busy_s[FRAME_CYC],     1);
    check("b2b_busy_done", busy_s[2*FRAME_CYC-1], 0);

`ifdef UART_TX_PARITY_EN
    tx_data = 8'h07; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    sample_n(FRAME_CYC + 1);
    check("par07_bit", line_s[9*BAUD], 1);
    check("par07_len", busy_s[FRAME_CYC], 0);
`endif

    // six bytes with valid held: fifth fills the FIFO, sixth waits for the first pop
    edge_no = 0;
    for (int k = 0; k < 6; k++) begin
      send(8'(8'h10 + k), w);
      edge_no += w;
      acc_edge[k] = edge_no;
      if (k == 4) begin
        check("hold_full_count", fifo_count, 4);
        check("hold_full_ready", tx_ready,   0);
      end
    end
    tx_valid = 1'b0;
    check("hold_b4_edge", acc_edge[4], 5);
    check("hold_b5_edge", acc_edge[5], FRAME_CYC + 3);
    drain();

    // reset during data bit 3 of 0x0F with two bytes queued behind it
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h81;
    @(posedge clk); #1;
    tx_data = 8'h82;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (4*BAUD - 2 + 1) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_line",  UART_TX,    1);
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_busy",  tx_busy,    0);
    @(posedge clk); #3 reset = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!UART_TX || tx_busy) low_cnt++;
    end
    check("rst_no_activity", low_cnt, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
